vend_coin_sched: RTL and testbench

//  Front-end scheduler for the soda vending core (15c price; nickel/dime/quarter

---
 rtl/vend_coin_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_vend_coin_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_sched.sv
// vend_coin_sched: round-robin two-slot coin front end for the 15c soda core.
// It also sequences the change as spaced single-nickel pulses. Optional counters: VEND_SCHED_STATS_EN.
module vend_coin_sched #(
  parameter int RESP_LAT = 1,
  parameter int PAY_GAP  = 2,
  parameter int CNT_W    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_valid_i,
  input  logic [1:0] a_coin_i,
  output logic       a_ready_o,
  input  logic       b_valid_i,
  input  logic [1:0] b_coin_i,
  output logic       b_ready_o,
  output logic       core_nickle_o,
  output logic       core_dime_o,
  output logic       core_quarter_o,
  input  logic       core_soda_i,
  input  logic [2:0] core_change_i,
  output logic       vend_o,
  output logic       pay_nickel_o,
  output logic       reject_o,
  output logic       busy_o
`ifdef VEND_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] coins_o,
  output logic [CNT_W-1:0] sodas_o,
  output logic [CNT_W-1:0] nickels_o
`endif
);

  // Wait counter holds RESP_LAT-1, gap counter holds PAY_GAP-2.
  localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam int GAP_W = (PAY_GAP > 2) ? $clog2(PAY_GAP - 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESP_LAT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((PAY_GAP > 1) ? (PAY_GAP - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RESULT = 3'd3,
    S_PAY    = 3'd4,
    S_GAP    = 3'd5
  } state_e;

  function automatic logic [2:0] clamp_change(input logic [2:0] chg);
    if (chg > 3'd4) begin
      return 3'd4;
    end else begin
      return chg;
    end
  endfunction

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [2:0]       pay_cnt_q, pay_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             nickle_q, nickle_d;
  logic             dime_q, dime_d;
  logic             quarter_q, quarter_d;
  logic             vend_q, vend_d;
  logic             pay_q, pay_d;
  logic             rej_q, rej_d;
  logic             busy_q, busy_d;

  logic             grant_a_s, grant_b_s, acc_s;
  logic [1:0]       acc_coin_s;

  // Grant selection; rr_q (0=A, 1=B) breaks ties only when both slots request.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (a_valid_i && b_valid_i) begin
        if (rr_q == 1'b0) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (a_valid_i) begin
        grant_a_s = 1'b1;
      end else if (b_valid_i) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
    end
  end

  assign acc_s      = grant_a_s | grant_b_s;
  assign acc_coin_s = grant_b_s ? b_coin_i : a_coin_i;
  assign a_ready_o  = grant_a_s;
  assign b_ready_o  = grant_b_s;

  // Next-state and next-output logic; every output is the registered image of its _d.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    pay_cnt_d = pay_cnt_q;
    lat_cnt_d = lat_cnt_q;
    gap_cnt_d = gap_cnt_q;
    nickle_d  = 1'b0;
    dime_d    = 1'b0;
    quarter_d = 1'b0;
    vend_d    = 1'b0;
    pay_d     = 1'b0;
    rej_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_valid_i && b_valid_i) begin
          rr_d = ~rr_q;
        end else begin
          rr_d = rr_q;
        end
        if (acc_s) begin
          case (acc_coin_s)
            2'b01:   begin nickle_d  = 1'b1; state_d = S_ISSUE; end
            2'b10:   begin dime_d    = 1'b1; state_d = S_ISSUE; end
            2'b11:   begin quarter_d = 1'b1; state_d = S_ISSUE; end
            default: begin rej_d     = 1'b1; state_d = S_IDLE;  end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == {LAT_W{1'b0}}) begin
          vend_d    = core_soda_i;
          pay_cnt_d = clamp_change(core_change_i);
          state_d   = S_RESULT;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_RESULT: begin
        if (pay_cnt_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          pay_d   = 1'b1;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        pay_cnt_d = pay_cnt_q - 3'd1;
        if (pay_cnt_q == 3'd1) begin
          state_d = S_IDLE;
        end else if (PAY_GAP == 1) begin
          pay_d   = 1'b1;
          state_d = S_PAY;
        end else begin
          gap_cnt_d = GAP_LOAD;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == {GAP_W{1'b0}}) begin
          pay_d   = 1'b1;
          state_d = S_PAY;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset drops any pending coin or payout.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      pay_cnt_q <= 3'd0;
      lat_cnt_q <= {LAT_W{1'b0}};
      gap_cnt_q <= {GAP_W{1'b0}};
      nickle_q  <= 1'b0;
      dime_q    <= 1'b0;
      quarter_q <= 1'b0;
      vend_q    <= 1'b0;
      pay_q     <= 1'b0;
      rej_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      pay_cnt_q <= pay_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      nickle_q  <= nickle_d;
      dime_q    <= dime_d;
      quarter_q <= quarter_d;
      vend_q    <= vend_d;
      pay_q     <= pay_d;
      rej_q     <= rej_d;
      busy_q    <= busy_d;
    end
  end

  assign core_nickle_o  = nickle_q;
  assign core_dime_o    = dime_q;
  assign core_quarter_o = quarter_q;
  assign vend_o         = vend_q;
  assign pay_nickel_o   = pay_q;
  assign reject_o       = rej_q;
  assign busy_o         = busy_q;

`ifdef VEND_SCHED_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] coins_q, sodas_q, nickels_q;

  // Wrapping statistics counters, stepped together with the pulses they count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      coins_q   <= {CNT_W{1'b0}};
      sodas_q   <= {CNT_W{1'b0}};
      nickels_q <= {CNT_W{1'b0}};
    end else begin
      if (nickle_d || dime_d || quarter_d) begin
        coins_q <= coins_q + CNT_ONE;
      end else begin
        coins_q <= coins_q;
      end
      if (vend_d) begin
        sodas_q <= sodas_q + CNT_ONE;
      end else begin
        sodas_q <= sodas_q;
      end
      if (pay_d) begin
        nickels_q <= nickels_q + CNT_ONE;
      end else begin
        nickels_q <= nickels_q;
      end
    end
  end

  assign coins_o   = coins_q;
  assign sodas_o   = sodas_q;
  assign nickels_o = nickels_q;
`endif

endmodule

// File: tb/tb_vend_coin_sched.sv
// Directed bench for vend_coin_sched with a behavioural 15c core model.
// Expected events are queued at stimulus time and matched against observed pulses.
module tb_vend_coin_sched;

  localparam int K_ARDY = 1, K_BRDY = 2, K_NICK = 3, K_DIME = 4, K_QTR = 5,
                 K_VEND = 6, K_PAY = 7, K_REJ = 8;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic [1:0] a_coin_i = 2'b00, b_coin_i = 2'b00;
  logic       a_ready_o, b_ready_o;
  logic       core_nickle_o, core_dime_o, core_quarter_o;
  logic       core_soda_i;
  logic [2:0] core_change_i;
  logic       vend_o, pay_nickel_o, reject_o, busy_o;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic busy_hist [0:1023];

  logic       ovr_en = 1'b0;
  logic [2:0] ovr_chg = 3'd0;
  logic [5:0] credit_q;
  logic       soda_q;
  logic [2:0] chg_q;
  int         val_s;
  int         tot_s;

  vend_coin_sched dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .a_valid_i     (a_valid_i),
    .a_coin_i      (a_coin_i),
    .a_ready_o     (a_ready_o),
    .b_valid_i     (b_valid_i),
    .b_coin_i      (b_coin_i),
    .b_ready_o     (b_ready_o),
    .core_nickle_o (core_nickle_o),
    .core_dime_o   (core_dime_o),
    .core_quarter_o(core_quarter_o),
    .core_soda_i   (core_soda_i),
    .core_change_i (core_change_i),
    .vend_o        (vend_o),
    .pay_nickel_o  (pay_nickel_o),
    .reject_o      (reject_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Core model: 15c price, registered soda/change, change in nickels.
  assign val_s = core_nickle_o ? 5 : (core_dime_o ? 10 : (core_quarter_o ? 25 : 0));
  assign tot_s = int'(credit_q) + val_s;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      credit_q <= 6'd0;
      soda_q   <= 1'b0;
      chg_q    <= 3'd0;
    end else if (val_s != 0 && tot_s >= 15) begin
      soda_q   <= 1'b1;
      chg_q    <= ovr_en ? ovr_chg : 3'((tot_s - 15) / 5);
      credit_q <= 6'd0;
    end else begin
      soda_q   <= 1'b0;
      chg_q    <= 3'd0;
      credit_q <= (val_s != 0) ? 6'(tot_s) : credit_q;
    end
  end
  assign core_soda_i   = soda_q;
  assign core_change_i = chg_q;

  // Monitor: record pulses and busy away from the active edge.
  always @(negedge clk_i) begin
    busy_hist[cyc[9:0]] <= busy_o;
    if (a_ready_o)      obs_q.push_back('{cyc, K_ARDY});
    if (b_ready_o)      obs_q.push_back('{cyc, K_BRDY});
    if (core_nickle_o)  obs_q.push_back('{cyc, K_NICK});
    if (core_dime_o)    obs_q.push_back('{cyc, K_DIME});
    if (core_quarter_o) obs_q.push_back('{cyc, K_QTR});
    if (vend_o)         obs_q.push_back('{cyc, K_VEND});
    if (pay_nickel_o)   obs_q.push_back('{cyc, K_PAY});
    if (reject_o)       obs_q.push_back('{cyc, K_REJ});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_ev(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Present one coin for a single cycle; the DUT is IDLE so it is granted at once.
  task automatic send(input bit slot_b, input logic [1:0] code, output int c);
    c = cyc;
    if (slot_b) begin
      b_valid_i = 1'b1;
      b_coin_i  = code;
    end else begin
      a_valid_i = 1'b1;
      a_coin_i  = code;
    end
    push_ev(c, slot_b ? K_BRDY : K_ARDY);
    push_ev(c + 1, (code == 2'b00) ? K_REJ : (K_NICK - 1 + int'(code)));
    @(posedge clk_i);
    #1;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
      end else begin
        o.cyc  = -1;
        o.kind = 0;
      end
      chk({tag, " event cycle"}, o.cyc, e.cyc);
      chk({tag, " event kind"}, o.kind, e.kind);
    end
    chk({tag, " extra events"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " a_ready"}, a_ready_o, 0);
    chk({tag, " b_ready"}, b_ready_o, 0);
    chk({tag, " core_nickle"}, core_nickle_o, 0);
    chk({tag, " core_dime"}, core_dime_o, 0);
    chk({tag, " core_quarter"}, core_quarter_o, 0);
    chk({tag, " vend"}, vend_o, 0);
    chk({tag, " pay_nickel"}, pay_nickel_o, 0);
    chk({tag, " reject"}, reject_o, 0);
    chk({tag, " busy"}, busy_o, 0);
  endtask

  initial begin
    int c, c2, c3;
    // Reset state
    #2 rst_i = 1'b0;
    #1 chk_quiet("reset");
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;

    // Nickel then dime: exact 15c, vend, no change
    send(1'b0, 2'b01, c);
    wait_until(c + 4);
    send(1'b0, 2'b10, c2);
    push_ev(c2 + 3, K_VEND);
    wait_until(c2 + 5);
    drain("nickel_dime");
    chk("nickel_dime busy in result", busy_hist[(c2 + 3) % 1024], 1);
    chk("nickel_dime busy back idle", busy_hist[(c2 + 4) % 1024], 0);

    // Quarter from 0c: 10c change -> two nickels, first one cycle after vend
    send(1'b0, 2'b11, c);
    push_ev(c + 3, K_VEND);
    push_ev(c + 4, K_PAY);
    push_ev(c + 6, K_PAY);
    wait_until(c + 8);
    drain("quarter");
    chk("quarter busy last pay", busy_hist[(c + 6) % 1024], 1);
    chk("quarter busy after pay", busy_hist[(c + 7) % 1024], 0);

    // 10c credit (A, B nickels) then quarter: four nickels two cycles apart
    send(1'b0, 2'b01, c);
    wait_until(c + 4);
    send(1'b1, 2'b01, c2);
    wait_until(c2 + 4);
    send(1'b0, 2'b11, c3);
    push_ev(c3 + 3, K_VEND);
    for (int i = 0; i < 4; i++) push_ev(c3 + 4 + 2 * i, K_PAY);
    wait_until(c3 + 12);
    drain("four_nickels");
    chk("four_nickels busy 4th pay", busy_hist[(c3 + 10) % 1024], 1);
    chk("four_nickels busy falls", busy_hist[(c3 + 11) % 1024], 0);

    // Core reports change code 6: payout clamps to four nickels
    ovr_en  = 1'b1;
    ovr_chg = 3'd6;
    send(1'b1, 2'b11, c);
    push_ev(c + 3, K_VEND);
    for (int i = 0; i < 4; i++) push_ev(c + 4 + 2 * i, K_PAY);
    wait_until(c + 12);
    ovr_en = 1'b0;
    drain("clamp");

    // Both slots held valid: grants alternate A,B,A,B; stalled slot waits for IDLE
    c = cyc;
    a_valid_i = 1'b1;
    a_coin_i  = 2'b01;
    b_valid_i = 1'b1;
    b_coin_i  = 2'b01;
    push_ev(c, K_ARDY);
    push_ev(c + 1, K_NICK);
    push_ev(c + 4, K_BRDY);
    push_ev(c + 5, K_NICK);
    push_ev(c + 8, K_ARDY);
    push_ev(c + 9, K_NICK);
    push_ev(c + 11, K_VEND);
    push_ev(c + 12, K_BRDY);
    push_ev(c + 13, K_NICK);
    wait_until(c + 13);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    wait_until(c + 18);
    drain("round_robin");

    // Invalid coin on B: accepted, rejected next cycle, never busy
    send(1'b1, 2'b00, c);
    wait_until(c + 4);
    drain("reject");
    chk("reject busy accept cycle", busy_hist[c % 1024], 0);
    chk("reject busy pulse cycle", busy_hist[(c + 1) % 1024], 0);
    chk("reject busy after", busy_hist[(c + 2) % 1024], 0);

    // 5c credit + quarter -> three nickels; reset lands during the second one
    send(1'b0, 2'b11, c);
    push_ev(c + 3, K_VEND);
    push_ev(c + 4, K_PAY);
    wait_until(c + 6);
    chk("midreset second nickel high", pay_nickel_o, 1);
    rst_i = 1'b0;
    #1 chk_quiet("midreset");
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;
    wait_until(c + 20);
    drain("midreset");
    chk("midreset busy later", busy_hist[(c + 12) % 1024], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
